llr_loader: RTL and testbench
=============================

// Module: llr_loader
// PURPOSE
//  Upstream feeder for the PE block's ping-pong intrinsic RAM. Accepts a stream of channel LLRs over
//  a valid/ready handshake and clamps each one to MESSAGE_WIDTH. Writes one frame of LLRs into the idle
//  intrinsic bank, then hands the bank to the decoder by toggling the bank select.
// PARAMETERS
//  IN_WIDTH       8    signed width of incoming channel LLR
//  MESSAGE_WIDTH  5    signed width of stored LLR (matches intrinsic RAM word)
//  ADDR_WIDTH     8    intrinsic RAM address width
//  FRAME_LEN      256  LLRs per frame, 2..2**ADDR_WIDTH
//  SCALE_SHIFT    2    right-shift amount; used only when LLR_SCALE_EN is defined
// PORTS
//  clk        in   1              clock, all logic on rising edge
//  rst        in   1              synchronous, active-high reset
//  in_valid   in   1              input beat valid
//  in_llr     in   IN_WIDTH       signed channel LLR
//  in_last    in   1              producer marks last beat of frame
//  in_ready   out  1              loader can accept a beat
//  wr_we      out  1              intrinsic RAM write enable (drives int_we/int_cs of fill bank)
//  wr_addr    out  ADDR_WIDTH     intrinsic RAM write address
//  wr_data    out  MESSAGE_WIDTH  saturated LLR
//  fill_bank  out  1              bank being written; int_rs = ~fill_bank
//  frame_rdy  out  1              filled bank waiting for decoder
//  dec_take   in   1              1-cycle pulse: decoder takes the ready frame
//  frame_err  out  1              1-cycle pulse: in_last mismatch
// BEHAVIOUR
//  States: FILL, DRAIN, READY. Reset values: state=FILL, count=0, fill_bank=1, wr_we=0, wr_addr=0,
//   wr_data=0, frame_rdy=0, frame_err=0.
//  in_ready = (state==FILL). A beat is accepted when in_valid & in_ready.
//  Accepted beat at cycle t: wr_we=1, wr_addr=count, wr_data=sat(in_llr) are registered and appear in
//   cycle t+1. count increments per beat.
//  FILL->DRAIN on the accepted beat with count==FRAME_LEN-1; count clears to 0.
//  DRAIN lasts 1 cycle, while the last write is on the bus. DRAIN->READY; frame_rdy=1 in READY.
//  READY: in_ready=0. dec_take=1 -> fill_bank toggles, frame_rdy=0, state FILL next cycle.
//   dec_take is ignored outside READY.
//  Frame length is set by count alone; in_last never ends a frame. frame_err pulses in cycle t+1 if
//   in_last=1 on an accepted beat with count!=FRAME_LEN-1, or in_last=0 on the final beat.
//  Saturation: symmetric clamp to [-(2**(MESSAGE_WIDTH-1)-1), +(2**(MESSAGE_WIDTH-1)-1)].
//   The most-negative code is never written.
//  Reset mid-frame: partial frame is discarded and no further writes occur. Restart at address 0, bank 1.
//  in_valid with in_ready=0: beat held by the producer, no side effects.
// CONFIGURATION
//  LLR_SCALE_EN defined: before clamping, x = (in_llr + 2**(SCALE_SHIFT-1)) >>> SCALE_SHIFT,
//   computed at IN_WIDTH+1 bits (round half up). Latency is unchanged.
//  LLR_SCALE_EN undefined: in_llr is clamped directly and SCALE_SHIFT is unused.
// STRUCTURE
//  Package ldpc_pkg: loader_state_t enum {FILL,DRAIN,READY}; function sat_llr(IN_WIDTH->MESSAGE_WIDTH);
//   the MESSAGE_WIDTH and ADDR_WIDTH default localparams, shared with the PE block.
//  Sub-module llr_sat: combinational scale (optional) + clamp, instantiated once.
// TESTING  (IN_WIDTH=8, MESSAGE_WIDTH=5, FRAME_LEN=4 unless noted)
//  Saturation: in_llr 100,-100,-16,7 -> wr_data +15,-15,-15,+7 at addr 0..3, each one cycle after accept.
//  Handoff: fill 4 beats -> DRAIN 1 cycle -> frame_rdy=1, in_ready=0; dec_take -> fill_bank 1->0,
//   next frame writes bank 0 from addr 0.
//  Backpressure: stream 6 beats continuously, dec_take held off 5 cycles -> beats 5,6 stall;
//   no writes occur in READY.
//  Framing errors: in_last on beat 2 -> frame_err pulse, frame still 4 beats long.
//   in_last missing on beat 4 -> frame_err pulse.
//  Reset mid-frame: rst after beat 2 -> wr_we=0, fill_bank=1; next beat is written to addr 0.
//  LLR_SCALE_EN, SCALE_SHIFT=2: in_llr 10,-10,100 -> 3,-2,+15.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared LDPC types, default widths and the LLR clamp helper (used by loader and PE block).
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package ldpc_pkg;

    // Default intrinsic RAM word width and address width. The PE block shares these values.
    localparam int LDPC_MESSAGE_WIDTH = 5;
    localparam int LDPC_ADDR_WIDTH    = 8;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        READY = 2'd2
    } loader_state_t;

    // Symmetric clamp to +/-(2**(msg_w-1)-1). The input is a sign-extended LLR.
    // The most-negative msg_w-bit code is never produced, so negation stays safe downstream.
    function automatic logic signed [31:0] sat_llr(input logic signed [31:0] x, input int msg_w);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (msg_w - 1)) - 32'sd1;
        if (x > lim) begin
            return lim;
        end else if (x < -lim) begin
            return -lim;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/llr_sat.sv
// Optional round-half-up scale (LLR_SCALE_EN), then symmetric clamp of one channel LLR.
// Latency: combinational, 0 cycles.
// Backpressure: n/a (pure datapath).
module llr_sat
    import ldpc_pkg::*;
#(
    parameter int IN_WIDTH      = 8,
    parameter int MESSAGE_WIDTH = LDPC_MESSAGE_WIDTH,
    parameter int SCALE_SHIFT   = 2
) (
    input  logic [IN_WIDTH-1:0]      i_llr,
    output logic [MESSAGE_WIDTH-1:0] o_llr
);

    logic signed [31:0] w_wide;

    if (SCALE_SHIFT < 1 || SCALE_SHIFT >= IN_WIDTH) begin : g_bad_shift
        $error("llr_sat: SCALE_SHIFT must be in 1..IN_WIDTH-1");
    end

`ifdef LLR_SCALE_EN
    // One extra bit so that adding the rounding constant to +max cannot overflow.
    localparam logic signed [IN_WIDTH:0] HALF = (IN_WIDTH+1)'(1 << (SCALE_SHIFT - 1));

    logic signed [IN_WIDTH:0] w_rounded;
    logic signed [IN_WIDTH:0] w_scaled;

    assign w_rounded = $signed({i_llr[IN_WIDTH-1], i_llr}) + HALF;
    assign w_scaled  = w_rounded >>> SCALE_SHIFT;
    assign w_wide    = $signed({{(31-IN_WIDTH){w_scaled[IN_WIDTH]}}, w_scaled});
`else
    assign w_wide    = $signed({{(32-IN_WIDTH){i_llr[IN_WIDTH-1]}}, i_llr});
`endif

    assign o_llr = MESSAGE_WIDTH'(sat_llr(w_wide, MESSAGE_WIDTH));

endmodule

// File: rtl/llr_loader.sv
// Clamps streamed channel LLRs and writes one frame into the idle intrinsic bank, then hands it off.
// Latency: an accepted beat appears on wr_* one cycle later. Optional LLR_SCALE_EN does not change latency.
// Backpressure: in_ready is low from the final beat until dec_take, which covers DRAIN and READY.
module llr_loader
    import ldpc_pkg::*;
#(
    parameter int IN_WIDTH      = 8,
    parameter int MESSAGE_WIDTH = LDPC_MESSAGE_WIDTH,
    parameter int ADDR_WIDTH    = LDPC_ADDR_WIDTH,
    parameter int FRAME_LEN     = 256,
    parameter int SCALE_SHIFT   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [IN_WIDTH-1:0]      in_llr,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     wr_we,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [MESSAGE_WIDTH-1:0] wr_data,
    output logic                     fill_bank,
    output logic                     frame_rdy,
    input  logic                     dec_take,
    output logic                     frame_err
);

    if (FRAME_LEN < 2 || FRAME_LEN > (1 << ADDR_WIDTH)) begin : g_bad_len
        $error("llr_loader: FRAME_LEN must be in 2..2**ADDR_WIDTH");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

    loader_state_t            r_state;
    loader_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0]    r_count;
    logic [ADDR_WIDTH-1:0]    r_wr_addr;
    logic [MESSAGE_WIDTH-1:0] r_wr_data;
    logic [MESSAGE_WIDTH-1:0] w_sat;
    logic                     r_wr_we;
    logic                     r_fill_bank;
    logic                     r_frame_err;
    logic                     w_accept;
    logic                     w_final_beat;

    llr_sat #(
        .IN_WIDTH      (IN_WIDTH),
        .MESSAGE_WIDTH (MESSAGE_WIDTH),
        .SCALE_SHIFT   (SCALE_SHIFT)
    ) u_sat (
        .i_llr (in_llr),
        .o_llr (w_sat)
    );

    // The frame boundary comes from the beat count alone. in_last is only cross-checked.
    assign w_accept     = in_valid & in_ready;
    assign w_final_beat = (r_count == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs. DRAIN is the one cycle in which the final write is on the bus.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        frame_rdy   = 1'b0;
        case (r_state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && w_final_beat) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = READY;
            end
            READY: begin
                frame_rdy = 1'b1;
                if (dec_take) begin
                    w_state_nxt = FILL;
                end
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    // Write port register, beat counter, framing check and bank toggle on handoff
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_wr_we     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
            r_fill_bank <= 1'b1;
        end else begin
            r_wr_we     <= w_accept;
            r_frame_err <= w_accept & (in_last ^ w_final_beat);
            if (w_accept) begin
                r_wr_addr <= r_count;
                r_wr_data <= w_sat;
                r_count   <= w_final_beat ? '0 : r_count + ADDR_WIDTH'(1);
            end
            if (r_state == READY && dec_take) begin
                r_fill_bank <= ~r_fill_bank;
            end
        end
    end

    assign wr_we     = r_wr_we;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign fill_bank = r_fill_bank;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_llr_loader.sv
// Directed bench for llr_loader with FRAME_LEN=4: saturation, handoff, framing errors, backpressure, reset.
// Latency: checks wr_* one cycle after each accepted beat.
// Backpressure: the producer holds each beat until in_ready is high.
module tb_llr_loader;

`ifdef LLR_SCALE_EN
    localparam bit SCALED = 1'b1;
`else
    localparam bit SCALED = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_llr;
    logic       in_last;
    logic       in_ready;
    logic       wr_we;
    logic [7:0] wr_addr;
    logic [4:0] wr_data;
    logic       fill_bank;
    logic       frame_rdy;
    logic       dec_take;
    logic       frame_err;

    int n_checks;
    int n_fail;

    llr_loader #(
        .IN_WIDTH      (8),
        .MESSAGE_WIDTH (5),
        .ADDR_WIDTH    (8),
        .FRAME_LEN     (4),
        .SCALE_SHIFT   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_llr    (in_llr),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .wr_we     (wr_we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .fill_bank (fill_bank),
        .frame_rdy (frame_rdy),
        .dec_take  (dec_take),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle's inputs, and the outputs expected just after the following rising edge.
    typedef struct {
        int v;
        int llr;
        int last;
        int take;
        int we;
        int addr;
        int dat;
        int dat_sc;
        int bank;
        int rdy;
        int err;
        int ir;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(int v, int llr, int last, int take, int we, int addr, int dat,
                                int dat_sc, int bank, int rdy, int err, int ir);
        vec_t r;
        r.v = v; r.llr = llr; r.last = last; r.take = take;
        r.we = we; r.addr = addr; r.dat = dat; r.dat_sc = dat_sc;
        r.bank = bank; r.rdy = rdy; r.err = err; r.ir = ir;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int wr_data_s();
        return int'($signed(wr_data));
    endfunction

    // Expected stored value for the backpressure beats, which use in_llr = 4*k.
    function automatic int exp_bp(int k);
        if (SCALED) return k;
        return (4 * k > 15) ? 15 : 4 * k;
    endfunction

    initial begin
        int beat;
        int rdy_cycles;
        int stalls;
        int acc;
        int ed;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_llr   = 8'd0;
        in_last  = 1'b0;
        dec_take = 1'b0;

        //        v  llr  last take we addr dat dat_sc bank rdy err ir
        tbl[0]  = mk(1,  100, 0, 0,  1, 0,  15,  15,  1, 0, 0, 1);
        tbl[1]  = mk(1, -100, 0, 0,  1, 1, -15, -15,  1, 0, 0, 1);
        tbl[2]  = mk(1,  -16, 0, 0,  1, 2, -15,  -4,  1, 0, 0, 1);
        tbl[3]  = mk(1,    7, 1, 0,  1, 3,   7,   2,  1, 0, 0, 0); // final beat -> DRAIN
        tbl[4]  = mk(1,   50, 0, 0,  0, 0,   0,   0,  1, 1, 0, 0); // held beat, READY
        tbl[5]  = mk(1,   50, 0, 0,  0, 0,   0,   0,  1, 1, 0, 0);
        tbl[6]  = mk(1,   50, 0, 1,  0, 0,   0,   0,  0, 0, 0, 1); // handoff, bank 1->0
        tbl[7]  = mk(1,   10, 0, 0,  1, 0,  10,   3,  0, 0, 0, 1);
        tbl[8]  = mk(1,  -10, 1, 0,  1, 1, -10,  -2,  0, 0, 1, 1); // early in_last
        tbl[9]  = mk(0,    0, 0, 0,  0, 0,   0,   0,  0, 0, 0, 1); // idle gap
        tbl[10] = mk(1,  100, 0, 0,  1, 2,  15,  15,  0, 0, 0, 1);
        tbl[11] = mk(1, -128, 0, 0,  1, 3, -15, -15,  0, 0, 1, 0); // missing in_last
        tbl[12] = mk(0,    0, 0, 1,  0, 0,   0,   0,  0, 1, 0, 0); // take in DRAIN ignored
        tbl[13] = mk(0,    0, 0, 0,  0, 0,   0,   0,  0, 1, 0, 0);
        tbl[14] = mk(0,    0, 0, 1,  0, 0,   0,   0,  1, 0, 0, 1); // handoff, bank 0->1

        // Reset state
        step();
        step();
        check("rst_we",       int'(wr_we),     0);
        check("rst_addr",     int'(wr_addr),   0);
        check("rst_data",     int'(wr_data),   0);
        check("rst_bank",     int'(fill_bank), 1);
        check("rst_frame_rdy", int'(frame_rdy), 0);
        check("rst_err",      int'(frame_err), 0);
        check("rst_in_ready", int'(in_ready),  1);
        rst = 1'b0;

        // Table: saturation, handoff, framing errors
        for (int i = 0; i < 15; i++) begin
            in_valid = tbl[i].v[0];
            in_llr   = 8'(tbl[i].llr);
            in_last  = tbl[i].last[0];
            dec_take = tbl[i].take[0];
            step();
            ed = SCALED ? tbl[i].dat_sc : tbl[i].dat;
            check($sformatf("v%0d_we", i),        int'(wr_we),     tbl[i].we);
            check($sformatf("v%0d_bank", i),      int'(fill_bank), tbl[i].bank);
            check($sformatf("v%0d_frame_rdy", i), int'(frame_rdy), tbl[i].rdy);
            check($sformatf("v%0d_err", i),       int'(frame_err), tbl[i].err);
            check($sformatf("v%0d_in_ready", i),  int'(in_ready),  tbl[i].ir);
            if (tbl[i].we != 0) begin
                check($sformatf("v%0d_addr", i), int'(wr_addr), tbl[i].addr);
                check($sformatf("v%0d_data", i), wr_data_s(),    ed);
            end
        end
        in_valid = 1'b0;
        dec_take = 1'b0;

        // Backpressure: six beats streamed back to back; dec_take held off for five READY cycles
        beat       = 1;
        rdy_cycles = 0;
        stalls     = 0;
        for (int cyc = 0; cyc < 40 && beat <= 6; cyc++) begin
            in_valid = 1'b1;
            in_llr   = 8'(4 * beat);
            in_last  = (beat == 4);
            dec_take = frame_rdy && (rdy_cycles == 5);
            if (frame_rdy) rdy_cycles++;
            acc = int'(in_ready);
            step();
            check("bp_we",       int'(wr_we), acc);
            check("bp_err",      int'(frame_err), 0);
            check("bp_wr_in_ready_state", int'(frame_rdy & wr_we), 0);
            if (acc != 0) begin
                check("bp_addr", int'(wr_addr),   (beat - 1) % 4);
                check("bp_data", wr_data_s(),     exp_bp(beat));
                check("bp_bank", int'(fill_bank), (beat <= 4) ? 1 : 0);
                beat++;
            end else begin
                stalls++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        dec_take = 1'b0;
        check("bp_all_beats_taken", beat, 7);
        check("bp_stall_cycles", stalls, 7);

        // Reset after two beats of a frame into bank 0
        rst = 1'b1;
        step();
        check("mrst_we",        int'(wr_we),     0);
        check("mrst_bank",      int'(fill_bank), 1);
        check("mrst_frame_rdy", int'(frame_rdy), 0);
        check("mrst_in_ready",  int'(in_ready),  1);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_llr   = 8'd9;
        step();
        in_valid = 1'b0;
        check("mrst_next_we",   int'(wr_we),     1);
        check("mrst_next_addr", int'(wr_addr),   0);
        check("mrst_next_data", wr_data_s(),     SCALED ? 2 : 9);
        check("mrst_next_bank", int'(fill_bank), 1);
        step();
        check("mrst_idle_we",   int'(wr_we),     0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
